fft_frame_ctrl: RTL and testbench
=================================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter N, default 3: log2 of the FFT frame length (frame length L = 1<<N).
REQ-002 Parameter LAT, default (1<<N)+N: cycles from fft_start asserted to the first valid FFT output sample.
REQ-003 Parameter CW, default 16: width of frame_cnt.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  frame-start enable; sampled only in IDLE.
REQ-007 in_valid  in  1  upstream sample valid.
REQ-008 in_data  in  fpt  upstream sample.
REQ-009 in_ready  out  1  sample accepted when in_valid&in_ready.
REQ-010 fft_start  out  1  start pulse to FFT pipeline, aligned with first sample of a frame.
REQ-011 fft_ip  out  fpt  sample to FFT pipeline input.
REQ-012 out_valid  out  1  FFT output window active.
REQ-013 out_first / out_last  out  1 each  first / last output sample of a frame.
REQ-014 out_idx  out  N  output sample index within frame.
REQ-015 busy  out  1  high in LOAD or while any started frame has not finished output.
REQ-016 underrun  out  1  sticky: zero-fill occurred.
REQ-017 frame_cnt  out  CW  completed output frames, wraps at 2^CW.

Function
REQ-018 FSM states IDLE, LOAD; sample counter cnt of N bits.
REQ-019 IDLE: in_ready = en; on accept, go to LOAD with cnt=1; next cycle fft_ip = in_data and fft_start = 1.
REQ-020 LOAD: in_ready = 1 regardless of en; the pipeline advances every cycle, so cnt increments each cycle whether or not in_valid is high.
REQ-021 LOAD, in_valid=0: fft_ip = 0 next cycle and underrun is set.
REQ-022 LOAD, cnt = L-1: this cycle carries the last sample; next state is IDLE.
REQ-023 Back-to-back frames: the IDLE cycle after LOAD accepts a new first sample, giving a gap of zero idle cycles between frames.
REQ-024 fft_ip and fft_start are registered with 1-cycle latency from accept; fft_start is high for exactly one cycle per frame; fft_ip = 0 when not in a frame.
REQ-025 fft_start drives a LAT-stage delay line; its output starts the output window.
REQ-026 Output window: out_valid is high for exactly L consecutive cycles starting LAT cycles after fft_start; out_idx runs 0..L-1; out_first at idx 0; out_last at idx L-1.
REQ-027 frame_cnt increments in the out_last cycle.
REQ-028 Windows cannot overlap because starts are at least L cycles apart; if the delay line re-fires on the out_last cycle, the new window begins next cycle with out_idx=0.
REQ-029 busy = (state==LOAD) | out_valid | (any delay-line bit set).
REQ-030 en falling mid-frame does not truncate the frame.

Reset
REQ-031 While rst_n=0, the following are forced to reset values: state=IDLE, cnt=0, delay line cleared, out_idx=0, frame_cnt=0, underrun=0, fft_start=0, fft_ip=0, out_valid/first/last=0, busy=0.
REQ-032 Reset mid-frame or mid-window discards all in-flight frames; no partial window is emitted after release.
REQ-033 in_ready is 0 during reset.

Structure
REQ-034 The fpt typedef and the log2/length constant helpers live in the shared package header used by fft and bf_stage.
REQ-035 The delay line is a sub-module fft_start_delay (parameter LAT, 1-bit in/out, async active-low reset, any-bit-set output).

Verification (N=3, LAT=11)
REQ-036 Reset, then en=1 and in_valid held for 8 cycles from t0 -> fft_start at t0+1; fft_ip carries samples 0..7 at t0+1..t0+8; out_valid at t0+12..t0+19; out_last at t0+19; frame_cnt=1.
REQ-037 16 continuous valid samples -> two fft_start pulses 8 cycles apart; two contiguous 8-cycle output windows; out_idx wraps 7->0; frame_cnt=2.
REQ-038 in_valid=0 on the 4th sample of a frame -> fft_ip=0 in that slot, underrun=1 and sticky, frame still 8 samples.
REQ-039 en=0 with in_valid=1 in IDLE -> in_ready=0, no fft_start; en dropped at cnt=3 -> frame completes.
REQ-040 rst_n asserted at t0+14 -> out_valid=0 immediately and stays 0 after release; busy=0; frame_cnt=0.

Source files
------------

// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and helpers for the FFT frame controller and its FFT datapath neighbours.
// Holds the sample type, the controller state encoding and the frame-length helpers.
package fft_frame_ctrl_pkg;

    localparam int FPT_W = 16;

    typedef logic signed [FPT_W-1:0] fpt;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } ctrl_state_e;

    function automatic int frame_len(input int log2_len);
        return 1 << log2_len;
    endfunction

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_ctrl_start_delay.sv
// fft_start_delay: LAT-stage shift register for the frame-start pulse.
// o_fire is the last stage; o_any reports whether any start is still in flight.
module fft_start_delay #(
    parameter int LAT = 11
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    output logic o_fire,
    output logic o_any
);

    logic [LAT-1:0] r_line;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_line <= '0;
        end else begin
            r_line[0] <= i_start;
            for (int k = 1; k < LAT; k++) begin
                r_line[k] <= r_line[k-1];
            end
        end
    end

    assign o_fire = r_line[LAT-1];
    assign o_any  = |r_line;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frames an upstream sample stream into 2**N-sample FFT frames and tracks the output window.
//   state   | meaning
//   ST_IDLE | waiting for the first sample of a frame (accepted only while i_en)
//   ST_LOAD | streaming samples 1..L-1 of the frame, zero-filling any gaps
module fft_frame_ctrl
    import fft_frame_ctrl_pkg::*;
#(
    parameter int N   = 3,
    parameter int LAT = (1 << N) + N,
    parameter int CW  = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_in_valid,
    input  fpt            i_in_data,
    output logic          o_in_ready,
    output logic          o_fft_start,
    output fpt            o_fft_ip,
    output logic          o_out_valid,
    output logic          o_out_first,
    output logic          o_out_last,
    output logic [N-1:0]  o_out_idx,
    output logic          o_busy,
    output logic          o_underrun,
    output logic [CW-1:0] o_frame_cnt
);

    localparam int           L        = frame_len(N);
    localparam logic [N-1:0] IDX_LAST = N'(L - 1);

    ctrl_state_e   r_state;
    ctrl_state_e   w_state_nxt;
    logic [N-1:0]  r_cnt;
    logic [N-1:0]  w_cnt_nxt;
    logic          w_in_ready;
    logic          w_start_nxt;
    fpt            w_ip_nxt;
    logic          w_zero_fill;

    logic          r_fft_start;
    fpt            r_fft_ip;
    logic          r_underrun;

    logic          w_fire;
    logic          w_line_any;
    logic          r_out_valid;
    logic [N-1:0]  r_out_idx;
    logic [CW-1:0] r_frame_cnt;
    logic          w_win_last;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_in_ready  = 1'b0;
        w_start_nxt = 1'b0;
        w_ip_nxt    = '0;
        w_zero_fill = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = i_en;
                if (i_en && i_in_valid) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = N'(1);
                    w_start_nxt = 1'b1;
                    w_ip_nxt    = i_in_data;
                end
            end
            ST_LOAD: begin
                // The FFT pipeline never stalls, so a missing sample becomes a zero slot.
                w_in_ready = 1'b1;
                w_cnt_nxt  = r_cnt + 1'b1;
                if (i_in_valid) begin
                    w_ip_nxt = i_in_data;
                end else begin
                    w_zero_fill = 1'b1;
                end
                if (r_cnt == IDX_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fft_start <= 1'b0;
            r_fft_ip    <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_fft_start <= w_start_nxt;
            r_fft_ip    <= w_ip_nxt;
            r_underrun  <= r_underrun | w_zero_fill;
        end
    end

    // Fed with fft_start's D input so the registered window opens exactly LAT cycles after fft_start.
    fft_start_delay #(
        .LAT (LAT)
    ) u_start_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_start_nxt),
        .o_fire  (w_fire),
        .o_any   (w_line_any)
    );

    assign w_win_last = r_out_valid && (r_out_idx == IDX_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_fire) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= '0;
            end else if (r_out_valid) begin
                r_out_idx <= r_out_idx + 1'b1;
                if (w_win_last) begin
                    r_out_valid <= 1'b0;
                end
            end
            if (w_win_last) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign o_in_ready  = i_rst_n & w_in_ready;
    assign o_fft_start = r_fft_start;
    assign o_fft_ip    = r_fft_ip;
    assign o_out_valid = r_out_valid;
    assign o_out_first = r_out_valid && (r_out_idx == '0);
    assign o_out_last  = w_win_last;
    assign o_out_idx   = r_out_idx;
    assign o_busy      = (r_state == ST_LOAD) | r_out_valid | w_line_any;
    assign o_underrun  = r_underrun;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: directed scenarios then random traffic,
// compared each cycle against a schedule-based model of frame start times.
module tb_fft_frame_ctrl;
    import fft_frame_ctrl_pkg::*;

    localparam int N   = 3;
    localparam int L   = 8;
    localparam int LAT = 11;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          in_valid = 1'b0;
    fpt            in_data = '0;
    logic          in_ready;
    logic          fft_start;
    fpt            fft_ip;
    logic          out_valid;
    logic          out_first;
    logic          out_last;
    logic [N-1:0]  out_idx;
    logic          busy;
    logic          underrun;
    logic [CW-1:0] frame_cnt;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    int   q_acc[$];
    fpt   exp_ip[int];
    int   underrun_from;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.N(N), .LAT(LAT), .CW(CW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_fft_start (fft_start),
        .o_fft_ip    (fft_ip),
        .o_out_valid (out_valid),
        .o_out_first (out_first),
        .o_out_last  (out_last),
        .o_out_idx   (out_idx),
        .o_busy      (busy),
        .o_underrun  (underrun),
        .o_frame_cnt (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_acc.delete();
        exp_ip.delete();
        underrun_from = 32'h7fff_ffff;
    endtask

    // Every accepted frame at cycle t fixes a schedule: start at t+1, load through t+L-1,
    // window at t+LAT+1 .. t+LAT+L, counted once the window has passed.
    task automatic check_cycle();
        logic        e_start, e_load, e_valid, e_busy, e_rdy;
        int          e_idx, e_cnt, t;
        logic [15:0] e_ip;
        e_start = 1'b0; e_load = 1'b0; e_valid = 1'b0; e_busy = 1'b0;
        e_idx = 0; e_cnt = 0;
        foreach (q_acc[i]) begin
            t = q_acc[i];
            if (cyc == t + 1) e_start = 1'b1;
            if (cyc >= t + 1 && cyc <= t + L - 1) e_load = 1'b1;
            if (cyc >= t + LAT + 1 && cyc <= t + LAT + L) begin
                e_valid = 1'b1;
                e_idx   = cyc - (t + LAT + 1);
            end
            if (cyc > t + LAT + L) e_cnt++;
            if (cyc >= t + 1 && cyc <= t + LAT + L) e_busy = 1'b1;
        end
        e_ip  = exp_ip.exists(cyc) ? exp_ip[cyc] : 16'h0;
        e_rdy = !rst_n ? 1'b0 : (e_load ? 1'b1 : en);
        check("in_ready",  in_ready,  e_rdy);
        check("fft_start", fft_start, e_start);
        check("fft_ip",    {16'h0, fft_ip}, {16'h0, e_ip});
        check("out_valid", out_valid, e_valid);
        check("out_first", out_first, e_valid && e_idx == 0);
        check("out_last",  out_last,  e_valid && e_idx == L - 1);
        if (e_valid) check("out_idx", out_idx, e_idx);
        check("busy",      busy,      e_busy);
        check("underrun",  underrun,  underrun_from <= cyc);
        check("frame_cnt", frame_cnt, e_cnt % 65536);
    endtask

    task automatic model_update();
        int t_load;
        t_load = -1;
        if (rst_n) begin
            foreach (q_acc[i]) begin
                if (cyc >= q_acc[i] + 1 && cyc <= q_acc[i] + L - 1) t_load = q_acc[i];
            end
            if (t_load >= 0) begin
                exp_ip[cyc + 1] = in_valid ? in_data : fpt'(0);
                if (!in_valid && underrun_from > cyc + 1) underrun_from = cyc + 1;
            end else if (en && in_valid) begin
                q_acc.push_back(cyc);
                exp_ip[cyc + 1] = in_data;
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic v, input fpt d);
        @(negedge clk);
        rst_n    = r;
        en       = e;
        in_valid = v;
        in_data  = d;
        #1;
        if (!r) model_reset();
        check_cycle();
        model_update();
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, fpt'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, fpt'(i + 50));
        idle(2);

        // Single frame, samples 0..7
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, fpt'(i));
        idle(14);
        check("frame1_cnt", frame_cnt, 1);

        // Two back-to-back frames
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, fpt'(100 + i));
        idle(22);
        check("b2b_cnt", frame_cnt, 3);

        // Gap on the 4th sample
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, (i != 3), fpt'(200 + i));
        idle(20);
        check("underrun_sticky", underrun, 1);
        check("gap_cnt", frame_cnt, 4);

        // en low in IDLE blocks the frame; en dropping at cnt=3 does not
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, fpt'(300 + i));
        check("idle_en_low_ready", in_ready, 0);
        for (int i = 0; i < 8; i++) step(1'b1, (i < 3), 1'b1, fpt'(400 + i));
        idle(20);
        check("en_drop_cnt", frame_cnt, 5);

        // Reset in the middle of the output window (t0+14)
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, fpt'(500 + i));
        idle(6);
        step(1'b0, 1'b0, 1'b0, fpt'(0));
        check("rst_out_valid", out_valid, 0);
        step(1'b0, 1'b0, 1'b0, fpt'(0));
        idle(20);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 700; i++) begin
            step(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) != 0), fpt'($urandom_range(0, 65535)));
        end
        idle(25);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
